// File: rtl/key_pkg.sv
// Shared constants and helpers for board-input conditioning (keys, switches).
package key_pkg;

    // Pin polarity of the board pushbuttons.
    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // Smallest counter width w with 2**w >= cycles (at least 1 bit).
    function automatic int cnt_width_for(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    // 10 ms qualification window at 50 MHz.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_CNT_WIDTH       = cnt_width_for(DEF_DEBOUNCE_CYCLES);

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain bringing an asynchronous board input into the clk domain.
module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    // Shift the pin through the chain; reset loads the idle level everywhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stages <= {STAGES{RESET_LEVEL}};
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low pushbutton for the key PIO in_port.
// Optional press/release strobes are built only when KEY_DEBOUNCE_EVENT_EN
// is defined; otherwise both strobe ports are tied low.
module key_debounce
    import key_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int   CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter logic RESET_LEVEL     = KEY_RELEASED
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync_q;
    logic                 key_out_q;
    logic [CNT_WIDTH-1:0] count;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (key_raw),
        .q       (sync_q)
    );

    // Stability counter: any cycle agreeing with key_out restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_out_q <= RESET_LEVEL;
            count     <= '0;
        end else if (sync_q == key_out_q) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            key_out_q <= sync_q;
            count     <= '0;
        end else begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    assign key_out = key_out_q;

`ifdef KEY_DEBOUNCE_EVENT_EN
    logic key_out_d;
    logic press_q;
    logic release_q;

    // Edge detect on the debounced level; strobes rise the edge after key_out moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_out_d <= RESET_LEVEL;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            key_out_d <= key_out_q;
            press_q   <= key_out_d & ~key_out_q;
            release_q <= ~key_out_d & key_out_q;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`else
    assign press_pulse   = 1'b0;
    assign release_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_key_debounce;

`ifdef KEY_DEBOUNCE_EVENT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic key_raw;
    logic key_out;
    logic press_pulse;
    logic release_pulse;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic raw;
        logic exp_key;
        logic exp_press;
        logic exp_release;
        bit   chk_cnt;
    } vec_t;

    vec_t vecs[$];

    key_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (3),
        .RESET_LEVEL     (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_raw       (key_raw),
        .key_out       (key_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic k, input logic p, input logic r);
        check({tag, " key_out"}, key_out, k);
        check({tag, " press_pulse"}, press_pulse, EV ? p : 1'b0);
        check({tag, " release_pulse"}, release_pulse, EV ? r : 1'b0);
        tests++;
        if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
            failed++;
            $display("FAIL %s both_pulses: got 11 expected not both high", tag);
        end
    endtask

    function automatic void add(input logic raw, input logic k, input logic p,
                                input logic r, input bit c);
        vec_t v;
        v.raw = raw; v.exp_key = k; v.exp_press = p; v.exp_release = r; v.chk_cnt = c;
        vecs.push_back(v);
    endfunction

    // Step on key_raw from the opposite level: edge 6 moves key_out, edge 7 strobes.
    function automatic void add_step(input logic raw);
        for (int e = 1; e <= 8; e++) begin
            add(raw, (e >= 6) ? raw : ~raw,
                (e == 7) && (raw == 1'b0), (e == 7) && (raw == 1'b1), 1'b0);
        end
    endfunction

    initial begin
        // Idle after reset: released, no strobes, counter parked at zero.
        for (int i = 0; i < 20; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add_step(1'b0);
        add_step(1'b1);
        // Bounce 0,0,1,1,0,0,1,1 then hold 0: final capture at edge 9, fall at 14.
        for (int e = 1; e <= 16; e++) begin
            logic raw;
            raw = (e <= 8) ? logic'(((e - 1) / 2) % 2) : 1'b0;
            add(raw, (e >= 14) ? 1'b0 : 1'b1, e == 15, 1'b0, 1'b0);
        end
        add_step(1'b1);

        reset_n = 1'b0;
        key_raw = 1'b1;
        repeat (3) step();
        check_outs("in_reset", 1'b1, 1'b0, 1'b0);
        check_cnt("in_reset count", int'(dut.count), 0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            key_raw = vecs[i].raw;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_key,
                       vecs[i].exp_press, vecs[i].exp_release);
            if (vecs[i].chk_cnt)
                check_cnt($sformatf("vec%0d count", i), int'(dut.count), 0);
        end

        // Reset mid-qualification: the partial count must be discarded.
        key_raw = 1'b0;
        repeat (3) step();
        check_cnt("midcount pre count", int'(dut.count), 1);
        reset_n = 1'b0;
        #1;
        check_outs("midcount reset", 1'b1, 1'b0, 1'b0);
        check_cnt("midcount reset count", int'(dut.count), 0);
        step();
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            check_outs($sformatf("requal e%0d", e), (e >= 6) ? 1'b0 : 1'b1, e == 7, 1'b0);
        end

        // Asynchronous reset from the pressed state, checked before any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("async reset", 1'b1, 1'b0, 1'b0);
        key_raw = 1'b1;
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_outs($sformatf("post reset e%0d", e), 1'b1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions one raw, active-low pushbutton from the board pin.
- Feeds the clean level into the key PIO's in_port, which the Nios II reads over Avalon.
- Synchronises the asynchronous pin into the clk domain.
- Rejects bounce with a stability counter.
- Optionally emits single-cycle press/release strobes for downstream edge-capture logic.

Parameters:
- SYNC_STAGES, 2: number of flip-flops in the synchroniser chain; legal range 2..4.
- DEBOUNCE_CYCLES, 500000: cycles the synchronised input must hold a new value before key_out follows. 500000 is 10 ms at 50 MHz. Must be ≥1.
- CNT_WIDTH, 19: counter width; must satisfy 2^CNT_WIDTH ≥ DEBOUNCE_CYCLES.
- RESET_LEVEL, 1'b1: value loaded into the synchroniser chain and key_out at reset (1 = released).

Ports:
- clk, input, 1: system clock, 50 MHz.
- reset_n, input, 1: asynchronous active-low reset.
- key_raw, input, 1: raw pin, active-low (0 = pressed); asynchronous to clk and bouncing.
- key_out, output, 1: debounced level, same polarity as key_raw; drives the PIO in_port.
- press_pulse, output, 1: one-cycle strobe when key_out goes 1→0.
- release_pulse, output, 1: one-cycle strobe when key_out goes 0→1.

Behaviour:
- Reset: reset_n low asynchronously sets:
  - every synchroniser stage = RESET_LEVEL
  - key_out = RESET_LEVEL
  - counter = 0
  - press_pulse = 0, release_pulse = 0
- Release of reset is sampled on the next rising clk edge; no other reset-related behaviour.
- Synchroniser: a shift chain of SYNC_STAGES flops. sync_q is the last stage. No logic sits between stages.
- Counter rule, evaluated each rising edge:
  - sync_q == key_out: counter ← 0.
  - sync_q != key_out and counter == DEBOUNCE_CYCLES−1: key_out ← sync_q, counter ← 0.
  - Otherwise: counter ← counter+1.
- Latency: for a clean step on key_raw held indefinitely, key_out updates on rising edge number SYNC_STAGES+DEBOUNCE_CYCLES. Edge 1 is the first edge at which stage 0 captures the new value. With defaults that is edge 500002.
- Glitch rejection: a single cycle where sync_q returns to key_out's value clears the counter. A bounce train therefore restarts the qualification window, and key_out never toggles on it.
- Pulses:
  - press_pulse = 1 in exactly the cycle after the edge where key_out changed 1→0.
  - release_pulse = 1 in the same way for 0→1.
  - The two are registered and never high simultaneously.
- Counter never wraps: it is bounded by the compare at DEBOUNCE_CYCLES−1.
- DEBOUNCE_CYCLES=1: key_out follows sync_q one cycle later, i.e. no filtering.
- Reset mid-qualification: the count is discarded and key_out returns to RESET_LEVEL. A key held pressed through reset is re-qualified from scratch: key_out falls SYNC_STAGES+DEBOUNCE_CYCLES edges after reset release, with a press_pulse.
- Simultaneous events: none possible. Only one qualified transition can occur per edge, and the counter clears on it.

Optional Feature:
- Macro: KEY_DEBOUNCE_EVENT_EN.
- Defined: press_pulse and release_pulse are generated as described above.
- Undefined:
  - Both ports remain present and are tied to constant 0.
  - The pulse registers are not built.
  - key_out behaviour is unchanged.

Decomposition:
- Shared package key_pkg holds:
  - KEY_PRESSED = 1'b0 and KEY_RELEASED = 1'b1
  - default DEBOUNCE_CYCLES and CNT_WIDTH constants for the 50 MHz clock
  - the function that derives a counter width from a cycle count
- One natural sub-module: sync_chain.
  - Parameterised SYNC_STAGES flop chain with asynchronous reset to RESET_LEVEL.
  - Reused for the other board inputs (switches).

Test Plan (sim with DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset with key_raw=1, then release reset → key_out=1, pulses 0, counter 0 for 20 cycles.
- Clean press: key_raw 1→0 and held → key_out falls on edge 6 after capture; press_pulse high for exactly 1 cycle, on edge 7.
- Bounce: key_raw toggles 0,1,0,1 every 2 cycles, then holds 0 → key_out stays 1 through the bounce and falls 6 edges after the final stable capture; exactly one press_pulse.
- Release: from pressed, key_raw→1 and held → key_out rises after 6 edges; one release_pulse, no press_pulse.
- Reset mid-count: key_raw=0, assert reset_n low after 3 cycles → key_out=1 immediately (asynchronous). After release, key_out falls 6 edges after release, with a press_pulse.
- Build without KEY_DEBOUNCE_EVENT_EN and repeat the clean press → key_out timing identical; press_pulse and release_pulse stay 0 throughout.
